bcd_seq_converter: RTL and testbench

//  Multi-cycle binary-to-packed-BCD converter (shift-and-add-3 / double dabble), one bit per clock.

---
 rtl/bcd_seq_converter.sv | 95 +++++++++
 tb/tb_bcd_seq_converter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Serial binary-to-packed-BCD converter (double dabble, one bit per clock); result valid BIN_W+1 cycles after accept.
// Backpressure: o_ready low from accept until the cycle after the done pulse; i_valid is ignored meanwhile.
module bcd_seq_converter #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int ACC_W   = 4 * DIGITS;
  localparam int CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int MAX_DEC = 10**DIGITS - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [BIN_W-1:0]   bin_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_q;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] sh;

  // Add-3 on every nibble in parallel, then one left shift of {acc, bin}.
  // The top accumulator bit falls off the end; that only happens when saturating.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    sh = {acc_adj, bin_q} << 1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      bin_q   <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_bcd   <= '0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            bin_q   <= i_bin;
            acc     <= '0;
            cnt     <= '0;
            ovf_q   <= (32'(i_bin) > MAX_DEC);
            o_ready <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= sh[ACC_W+BIN_W-1:BIN_W];
          bin_q <= sh[BIN_W-1:0];
          if (cnt == LAST_CNT) begin
            // Result registered on the final shift so it is visible throughout DONE.
            o_bcd   <= ovf_q ? {DIGITS{4'h9}} : sh[ACC_W+BIN_W-1:BIN_W];
            o_ovf   <= ovf_q;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: vector table, handshake/latency corners, async abort, sparse sweep.
module tb_bcd_seq_converter;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [13:0] i_bin;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_bcd;
  logic        o_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_seq_converter #(.BIN_W(14), .DIGITS(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_bin   (i_bin),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_bcd   (o_bcd),
    .o_ovf   (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full transaction: accept, latency, result, pulse width, ready recovery.
  task automatic do_conv(input logic [13:0] b, input logic [15:0] eb, input logic eo, input string nm);
    int lat;
    int rdy_hi;
    @(negedge i_clk);
    chk({nm, " ready_before"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_bin   = b;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_bin   = ~b;
    lat    = 1;
    rdy_hi = 0;
    while (!o_valid && lat < 40) begin
      if (o_ready) rdy_hi++;
      @(negedge i_clk);
      lat++;
    end
    if (o_ready) rdy_hi++;
    chk({nm, " latency"}, 32'(lat), 32'd15);
    chk({nm, " bcd"}, 32'(o_bcd), 32'(eb));
    chk({nm, " ovf"}, 32'(o_ovf), 32'(eo));
    chk({nm, " ready_low"}, 32'(rdy_hi), 32'd0);
    @(negedge i_clk);
    chk({nm, " pulse_1cyc"}, 32'(o_valid), 32'd0);
    chk({nm, " ready_back"}, 32'(o_ready), 32'd1);
    chk({nm, " bcd_held"}, 32'(o_bcd), 32'(eb));
  endtask

  task automatic wait_pulse(output int t, output bit ok);
    int n;
    n = 0;
    while (!o_valid && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    ok = o_valid;
    t  = cyc;
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  vec_t vecs[10];

  initial begin
    int  t1, t2, pulses;
    bit  ok;

    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd4095,  16'h4095, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd10000, 16'h9999, 1'b1};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1};
    vecs[5] = '{14'd1,     16'h0001, 1'b0};
    vecs[6] = '{14'd5,     16'h0005, 1'b0};
    vecs[7] = '{14'd8191,  16'h8191, 1'b0};
    vecs[8] = '{14'd1000,  16'h1000, 1'b0};
    vecs[9] = '{14'd9,     16'h0009, 1'b0};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_bin   = '0;
    #2;
    chk("reset ready", 32'(o_ready), 32'd1);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset bcd",   32'(o_bcd),   32'd0);
    chk("reset ovf",   32'(o_ovf),   32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Back-to-back with i_valid held high: second word only taken after DONE.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_bin   = 14'd123;
    @(negedge i_clk);
    i_bin   = 14'd456;
    wait_pulse(t1, ok);
    chk("t4 first pulse", 32'(ok), 32'd1);
    chk("t4 first bcd", 32'(o_bcd), 32'h0123);
    @(negedge i_clk);
    wait_pulse(t2, ok);
    i_valid = 1'b0;
    chk("t4 second pulse", 32'(ok), 32'd1);
    chk("t4 second bcd", 32'(o_bcd), 32'h0456);
    chk("t4 spacing", 32'(t2 - t1), 32'd16);
    @(negedge i_clk);

    // Asynchronous reset in the middle of a conversion.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_bin   = 14'd1234;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (6) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("t5 abort ready", 32'(o_ready), 32'd1);
    chk("t5 abort bcd",   32'(o_bcd),   32'd0);
    chk("t5 abort ovf",   32'(o_ovf),   32'd0);
    chk("t5 abort valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    i_rst  = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_valid) pulses++;
    end
    chk("t5 no pulse", 32'(pulses), 32'd0);
    do_conv(14'd58, 16'h0058, 1'b0, "t5 58");

    // Sparse sweep across the full input range against a decimal reference.
    for (int v = 0; v < 16384; v += 41) begin
      do_conv(14'(v), ref_bcd(v), (v > 9999), $sformatf("sweep%0d", v));
    end
    do_conv(14'd9998, ref_bcd(9998), 1'b0, "sweep9998");
    do_conv(14'd10001, ref_bcd(10001), 1'b1, "sweep10001");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
